zeroriscy_register_file_mp: RTL and testbench
=============================================

Name: zeroriscy_register_file_mp

Overview:
Flip-flop register file for zero-riscy, generalised to N read ports and two write ports. Write port A is the ALU/single-cycle path; write port B is the long-latency LSU/multiplier path. A per-register pending scoreboard flags registers awaiting a port-B writeback. A sequential clear engine zeroes the whole file on request (context scrub / debug). Sits in the ID stage in place of the single-write-port file.

Parameters:
RV32E, 0, 1 -> 16 architectural registers (ADDR_WIDTH=4); 0 -> 32 (ADDR_WIDTH=5); NUM_WORDS=2**ADDR_WIDTH
DATA_WIDTH, 32, register width in bits
NUM_RPORTS, 3, number of read ports (1..4)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
test_en_i  in  1  test mode; no functional effect in this FF implementation
raddr_i  in  NUM_RPORTS*5  read addresses, port k at [5k+4:5k]
rdata_o  out  NUM_RPORTS*DATA_WIDTH  read data, port k at [DATA_WIDTH*(k+1)-1:DATA_WIDTH*k]
rbusy_o  out  NUM_RPORTS  pending bit of the register addressed by each read port
waddr_a_i  in  5  port A write address
wdata_a_i  in  DATA_WIDTH  port A write data
we_a_i  in  1  port A write enable
waddr_b_i  in  5  port B write address
wdata_b_i  in  DATA_WIDTH  port B write data
we_b_i  in  1  port B write enable; also clears the pending bit
pend_set_i  in  1  mark pend_addr_i as awaiting port-B writeback
pend_addr_i  in  5  scoreboard set address
clr_req_i  in  1  start clear sequence (sampled in IDLE only)
clr_busy_o  out  1  high while the clear engine is in CLEAR
clr_done_o  out  1  single-cycle pulse when the clear completes

Behaviour:
- Reset: all registers 0, all pending bits 0, FSM IDLE, clr_busy_o=0, clr_done_o=0. rdata_o=0 and rbusy_o=0 for every port.
- Addressing: with RV32E=1 only addr[3:0] is decoded and addr[4] is ignored (x16..x31 alias x0..x15). This applies to all address inputs.
- Register 0: reads 0 always. Writes to it are dropped. Its pending bit is never set.
- Reads: combinational, zero latency. Without the bypass feature, a write is visible on rdata_o the cycle after we_*.
- Writes: take effect on the rising clk edge when we_*=1.
- Write collision (both ports, same address, same cycle): port A data wins (younger instruction). Port B still clears the pending bit.
- Scoreboard:
  - pend_set_i sets pend[pend_addr_i] at the edge.
  - we_b_i clears pend[waddr_b_i] at the edge.
  - Set and clear of the same address in the same cycle: set wins (bit stays 1).
  - Port A writes never affect pending bits.
  - rbusy_o[k] = pend[raddr_k], combinational.
- Clear FSM, states IDLE -> CLEAR -> DONE -> IDLE:
  - IDLE: clr_req_i=1 -> CLEAR. At that edge, load the 1-based counter cnt=1 and clear all pending bits.
  - CLEAR: each cycle zero reg[cnt] and increment cnt. When cnt==NUM_WORDS-1 that register is zeroed and the FSM goes to DONE. CLEAR therefore lasts NUM_WORDS-1 cycles (31, or 15 with RV32E).
  - DONE: clr_done_o=1 for exactly one cycle, then IDLE.
  - clr_busy_o=1 only in CLEAR.
  - In CLEAR and DONE: we_a_i, we_b_i and pend_set_i are ignored (dropped, not queued), and clr_req_i is ignored.
  - Reads stay functional and return partially cleared contents.
- Reset asserted mid-clear: FSM returns to IDLE and all state is zeroed immediately (asynchronous). No done pulse.
- cnt width is ADDR_WIDTH. Wrap-around is never reached because the exit condition is the compare.

Optional Feature:
ZERORISCY_RF_BYPASS_EN
- Defined: each read port forwards same-cycle write data combinationally. If raddr_k matches an enabled port A or port B write (nonzero, not in CLEAR/DONE), rdata_k returns that data; port A takes priority over port B. Also, if raddr_k matches an enabled we_b_i address, rbusy_o[k] reads 0 that cycle unless pend_set_i targets the same address.
- Undefined: no forwarding. Reads return the registered contents only, and rbusy_o reflects registered pending bits.

Test Plan:
- Reset, then read all ports at x5 -> rdata_o=0, rbusy_o=0. Write A x5=0xDEADBEEF, next cycle read x5 on ports 0..2 -> 0xDEADBEEF on each.
- Same cycle we_a x7=0x11 and we_b x7=0x22 -> next cycle x7=0x11. If pend[x7] was 1 it is now 0.
- pend_set x9, then read x9 -> rbusy=1. Same cycle pend_set x9 with we_b x9=0x33 -> pend stays 1, x9=0x33. Next we_b alone -> rbusy=0.
- Write x0=0xFFFFFFFF via both ports and pend_set x0 -> x0 reads 0, rbusy=0.
- Fill x1..x31 with nonzero values and pulse clr_req:
  - clr_busy=1 for 31 cycles, then clr_done=1 for 1 cycle, then all registers read 0.
  - we_a to x3 issued mid-clear is dropped.
  - rst_n pulsed at cycle 10 of the clear -> clr_busy=0 immediately, no clr_done pulse.
- With ZERORISCY_RF_BYPASS_EN: we_a x4=0x55 and read x4 in the same cycle -> rdata=0x55. Without the macro -> old value 0.

Source files
------------

// File: rtl/zeroriscy_register_file_mp.sv
// zeroriscy_register_file_mp
// Flip-flop register file for the zero-riscy ID stage. It has NUM_RPORTS
// combinational read ports and two write ports. Port A carries ALU and other
// single-cycle results. Port B carries long-latency LSU and multiplier results.
// A per-register pending scoreboard marks registers that are waiting for a
// port-B writeback. A sequential clear engine zeroes the whole file on request.
//
// Parameters:
//   RV32E       1 -> 16 registers (addr[4] ignored), 0 -> 32 registers
//   DATA_WIDTH  register width
//   NUM_RPORTS  number of read ports (1..4)
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   test_en_i       test mode; no functional effect here
//   raddr_i         read addresses, port k at [5k+4:5k]
//   rdata_o         read data, port k at [DATA_WIDTH*(k+1)-1:DATA_WIDTH*k]
//   rbusy_o         pending bit of the register each read port addresses
//   waddr_a_i, wdata_a_i, we_a_i   write port A (wins collisions)
//   waddr_b_i, wdata_b_i, we_b_i   write port B (also clears the pending bit)
//   pend_set_i, pend_addr_i        scoreboard set request
//   clr_req_i       start the clear sequence (accepted in IDLE only)
//   clr_busy_o      high while registers are being zeroed
//   clr_done_o      one-cycle pulse when the clear completes
//
// Optional build macro ZERORISCY_RF_BYPASS_EN: each read port forwards the
// same-cycle write data and the pending-bit clear.
module zeroriscy_register_file_mp #(
  parameter int RV32E      = 0,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           test_en_i,
  input  logic [NUM_RPORTS*5-1:0]        raddr_i,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_RPORTS-1:0]          rbusy_o,
  input  logic [4:0]                     waddr_a_i,
  input  logic [DATA_WIDTH-1:0]          wdata_a_i,
  input  logic                           we_a_i,
  input  logic [4:0]                     waddr_b_i,
  input  logic [DATA_WIDTH-1:0]          wdata_b_i,
  input  logic                           we_b_i,
  input  logic                           pend_set_i,
  input  logic [4:0]                     pend_addr_i,
  input  logic                           clr_req_i,
  output logic                           clr_busy_o,
  output logic                           clr_done_o
);

  localparam int ADDR_WIDTH = (RV32E != 0) ? 4 : 5;
  localparam int NUM_WORDS  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    clr_busy_q;
  logic                    clr_done_q;

  logic [DATA_WIDTH-1:0]   mem [NUM_WORDS];
  logic [NUM_WORDS-1:0]    pend;

  logic [ADDR_WIDTH-1:0]   wa;
  logic [ADDR_WIDTH-1:0]   wb;
  logic [ADDR_WIDTH-1:0]   pa;
  logic                    wr_open;
  logic                    we_a;
  logic                    we_b;
  logic                    pend_set;
  logic                    clr_start;

  // Only the low ADDR_WIDTH bits are decoded. With RV32E, x16..x31 alias x0..x15.
  assign wa = waddr_a_i[ADDR_WIDTH-1:0];
  assign wb = waddr_b_i[ADDR_WIDTH-1:0];
  assign pa = pend_addr_i[ADDR_WIDTH-1:0];

  // Updates are dropped while the clear engine owns the file (CLEAR and DONE).
  // Requests that target x0 are also dropped, so x0 and pend[0] stay 0.
  assign wr_open   = (state == IDLE);
  assign we_a      = we_a_i     && wr_open && (wa != '0);
  assign we_b      = we_b_i     && wr_open && (wb != '0);
  assign pend_set  = pend_set_i && wr_open && (pa != '0);
  assign clr_start = clr_req_i  && wr_open;

  // Clear engine. The status outputs are registered together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          clr_done_q <= 1'b0;
          if (clr_req_i) begin
            state      <= CLEAR;
            cnt        <= ADDR_WIDTH'(1);
            clr_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          // The compare exits before cnt can wrap.
          if (cnt == LAST_ADDR) begin
            state      <= DONE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        DONE: begin
          state      <= IDLE;
          clr_done_q <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          clr_busy_q <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy_o = clr_busy_q;
  assign clr_done_o = clr_done_q;

  // Register array. Entry 0 is only ever reset, so it stays 0.
  // When both ports write the same register, port A wins because it carries
  // the younger instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_WORDS; i++) begin
        if ((state == CLEAR) && (cnt == ADDR_WIDTH'(i))) begin
          mem[i] <= '0;
        end else if (we_a && (wa == ADDR_WIDTH'(i))) begin
          mem[i] <= wdata_a_i;
        end else if (we_b && (wb == ADDR_WIDTH'(i))) begin
          mem[i] <= wdata_b_i;
        end
      end
    end
  end

  // Pending scoreboard. If the same register is set and cleared in one cycle,
  // the set wins: a new long-latency op was issued as the old one retired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (clr_start) begin
      pend <= '0;
    end else begin
      for (int i = 1; i < NUM_WORDS; i++) begin
        if (pend_set && (pa == ADDR_WIDTH'(i))) begin
          pend[i] <= 1'b1;
        end else if (we_b && (wb == ADDR_WIDTH'(i))) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Read ports
  for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rport
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rb;

    assign ra = raddr_i[5*k +: ADDR_WIDTH];

    always_comb begin
      rd = (ra == '0) ? '0 : mem[ra];
      rb = pend[ra];
`ifdef ZERORISCY_RF_BYPASS_EN
      // we_a and we_b are already qualified as nonzero and not clearing.
      if (we_a && (wa == ra)) begin
        rd = wdata_a_i;
      end else if (we_b && (wb == ra)) begin
        rd = wdata_b_i;
      end
      if (we_b && (wb == ra) && !(pend_set && (pa == ra))) begin
        rb = 1'b0;
      end
`endif
    end

    assign rdata_o[DATA_WIDTH*k +: DATA_WIDTH] = rd;
    assign rbusy_o[k] = rb;
  end

  // test_en_i has no effect in a flop-based file. The upper address bits are
  // unused under RV32E.
  logic unused_ok;
  assign unused_ok = ^{test_en_i, raddr_i, waddr_a_i, waddr_b_i, pend_addr_i};

endmodule

// File: tb/tb_zeroriscy_register_file_mp.sv
module tb_zeroriscy_register_file_mp;

  localparam int RV32E      = 0;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_RPORTS = 3;
  localparam int AW         = (RV32E != 0) ? 4 : 5;
  localparam int NW         = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_en_i = 1'b0;
  logic [NUM_RPORTS*5-1:0]          raddr_i = '0;
  logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o;
  logic [NUM_RPORTS-1:0]            rbusy_o;
  logic [4:0]                       waddr_a_i = '0;
  logic [DATA_WIDTH-1:0]            wdata_a_i = '0;
  logic                             we_a_i = 1'b0;
  logic [4:0]                       waddr_b_i = '0;
  logic [DATA_WIDTH-1:0]            wdata_b_i = '0;
  logic                             we_b_i = 1'b0;
  logic                             pend_set_i = 1'b0;
  logic [4:0]                       pend_addr_i = '0;
  logic                             clr_req_i = 1'b0;
  logic                             clr_busy_o;
  logic                             clr_done_o;

  always #5 clk = ~clk;

  zeroriscy_register_file_mp #(
    .RV32E(RV32E), .DATA_WIDTH(DATA_WIDTH), .NUM_RPORTS(NUM_RPORTS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .test_en_i(test_en_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .rbusy_o(rbusy_o),
    .waddr_a_i(waddr_a_i), .wdata_a_i(wdata_a_i), .we_a_i(we_a_i),
    .waddr_b_i(waddr_b_i), .wdata_b_i(wdata_b_i), .we_b_i(we_b_i),
    .pend_set_i(pend_set_i), .pend_addr_i(pend_addr_i),
    .clr_req_i(clr_req_i), .clr_busy_o(clr_busy_o), .clr_done_o(clr_done_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural registers and pending flags, plus the age
  // of the current clear request. clr_age < 0 means no clear is running. For
  // ages 1..NW-1 register clr_age is zeroed at the next edge. Age NW is the
  // done cycle.
  logic [DATA_WIDTH-1:0] m_reg [NW];
  bit                    m_pend [NW];
  int                    clr_age = -1;

  function automatic int dec(input logic [4:0] a);
    return int'(a) & (NW - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    clr_age = -1;
  endtask

  task automatic model_edge();
    int a, b, p;
    a = dec(waddr_a_i);
    b = dec(waddr_b_i);
    p = dec(pend_addr_i);
    if (!rst_n) begin
      model_reset();
    end else if (clr_age < 0) begin
      if (we_b_i && b != 0) begin
        m_reg[b]  = wdata_b_i;
        m_pend[b] = 1'b0;
      end
      if (we_a_i && a != 0) m_reg[a] = wdata_a_i;
      if (pend_set_i && p != 0) m_pend[p] = 1'b1;
      if (clr_req_i) begin
        for (int i = 0; i < NW; i++) m_pend[i] = 1'b0;
        clr_age = 1;
      end
    end else begin
      if (clr_age <= NW - 1) m_reg[clr_age] = '0;
      clr_age++;
      if (clr_age > NW) clr_age = -1;
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] exp_rd(input logic [4:0] addr);
    int i;
    logic [DATA_WIDTH-1:0] v;
    i = dec(addr);
    v = (i == 0) ? '0 : m_reg[i];
`ifdef ZERORISCY_RF_BYPASS_EN
    if (clr_age < 0 && i != 0) begin
      if (we_a_i && dec(waddr_a_i) == i) v = wdata_a_i;
      else if (we_b_i && dec(waddr_b_i) == i) v = wdata_b_i;
    end
`endif
    return v;
  endfunction

  function automatic logic exp_bz(input logic [4:0] addr);
    int i;
    logic v;
    i = dec(addr);
    v = m_pend[i];
`ifdef ZERORISCY_RF_BYPASS_EN
    if (clr_age < 0 && i != 0 && we_b_i && dec(waddr_b_i) == i &&
        !(pend_set_i && dec(pend_addr_i) == i)) v = 1'b0;
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input logic [DATA_WIDTH-1:0] obs,
                     input logic [DATA_WIDTH-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NUM_RPORTS; k++) begin
      chk($sformatf("%s rdata%0d", tag, k), rdata_o[DATA_WIDTH*k +: DATA_WIDTH],
          exp_rd(raddr_i[5*k +: 5]));
      chk($sformatf("%s rbusy%0d", tag, k), DATA_WIDTH'(rbusy_o[k]),
          DATA_WIDTH'(exp_bz(raddr_i[5*k +: 5])));
    end
    chk({tag, " clr_busy"}, DATA_WIDTH'(clr_busy_o),
        DATA_WIDTH'(clr_age >= 1 && clr_age <= NW - 1));
    chk({tag, " clr_done"}, DATA_WIDTH'(clr_done_o), DATA_WIDTH'(clr_age == NW));
  endtask

  task automatic idle_inputs();
    we_a_i = 1'b0; we_b_i = 1'b0; pend_set_i = 1'b0; clr_req_i = 1'b0;
  endtask

  task automatic read_all(input logic [4:0] a);
    for (int k = 0; k < NUM_RPORTS; k++) raddr_i[5*k +: 5] = a;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle_check(input string tag);
    #1;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt;
    model_reset();
    idle_inputs();
    read_all(5'd5);
    #3;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Port A write, then read on all ports
    we_a_i = 1'b1; waddr_a_i = 5'd5; wdata_a_i = 32'hDEADBEEF;
    settle_check("wa_x5_same");
    tick();
    idle_inputs();
    settle_check("wa_x5_next");
    chk("x5_port0", rdata_o[DATA_WIDTH-1:0], 32'hDEADBEEF);

    // Collision on x7 with a pending bit set beforehand
    pend_set_i = 1'b1; pend_addr_i = 5'd7; read_all(5'd7);
    settle_check("pend_x7");
    tick();
    idle_inputs();
    we_a_i = 1'b1; waddr_a_i = 5'd7; wdata_a_i = 32'h11;
    we_b_i = 1'b1; waddr_b_i = 5'd7; wdata_b_i = 32'h22;
    settle_check("coll_x7_same");
    chk("x7_busy_before", DATA_WIDTH'(m_pend[7]), DATA_WIDTH'(1));
    tick();
    idle_inputs();
    settle_check("coll_x7_next");
    chk("x7_a_wins", rdata_o[DATA_WIDTH-1:0], 32'h11);
    chk("x7_pend_clr", DATA_WIDTH'(rbusy_o[0]), '0);

    // Scoreboard on x9: set, set+clear same cycle, clear alone
    pend_set_i = 1'b1; pend_addr_i = 5'd9; read_all(5'd9);
    tick();
    idle_inputs();
    settle_check("pend_x9");
    chk("x9_busy", DATA_WIDTH'(rbusy_o[1]), DATA_WIDTH'(1));
    pend_set_i = 1'b1; pend_addr_i = 5'd9;
    we_b_i = 1'b1; waddr_b_i = 5'd9; wdata_b_i = 32'h33;
    settle_check("setclr_x9_same");
    tick();
    idle_inputs();
    settle_check("setclr_x9_next");
    chk("x9_set_wins", DATA_WIDTH'(rbusy_o[2]), DATA_WIDTH'(1));
    chk("x9_data", rdata_o[DATA_WIDTH-1:0], 32'h33);
    we_b_i = 1'b1; waddr_b_i = 5'd9; wdata_b_i = 32'h44;
    settle_check("clr_x9_same");
    tick();
    idle_inputs();
    settle_check("clr_x9_next");
    chk("x9_cleared", DATA_WIDTH'(rbusy_o[0]), '0);

    // x0 is immune to writes and scoreboard sets
    we_a_i = 1'b1; waddr_a_i = 5'd0; wdata_a_i = 32'hFFFFFFFF;
    we_b_i = 1'b1; waddr_b_i = 5'd0; wdata_b_i = 32'hFFFFFFFF;
    pend_set_i = 1'b1; pend_addr_i = 5'd0; read_all(5'd0);
    settle_check("x0_same");
    tick();
    idle_inputs();
    settle_check("x0_next");
    chk("x0_data", rdata_o[DATA_WIDTH-1:0], '0);
    chk("x0_busy", DATA_WIDTH'(rbusy_o[0]), '0);

    // Same-cycle read of a register being written
    we_a_i = 1'b1; waddr_a_i = 5'd4; wdata_a_i = 32'h55; read_all(5'd4);
    #1;
`ifdef ZERORISCY_RF_BYPASS_EN
    chk("bypass_x4", rdata_o[DATA_WIDTH-1:0], 32'h55);
`else
    chk("nobypass_x4", rdata_o[DATA_WIDTH-1:0], 32'h0);
`endif
    check_all("x4_same");
    tick();
    idle_inputs();

    // Randomized traffic, including occasional clears
    for (int c = 0; c < 400; c++) begin
      we_a_i      = ($urandom_range(0, 2) != 0);
      waddr_a_i   = 5'($urandom);
      wdata_a_i   = DATA_WIDTH'($urandom);
      we_b_i      = ($urandom_range(0, 2) != 0);
      waddr_b_i   = ($urandom_range(0, 3) == 0) ? waddr_a_i : 5'($urandom);
      wdata_b_i   = DATA_WIDTH'($urandom);
      pend_set_i  = ($urandom_range(0, 1) != 0);
      pend_addr_i = ($urandom_range(0, 3) == 0) ? waddr_b_i : 5'($urandom);
      clr_req_i   = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < NUM_RPORTS; k++) begin
        raddr_i[5*k +: 5] = ($urandom_range(0, 2) == 0) ? waddr_a_i :
                            ($urandom_range(0, 2) == 0) ? waddr_b_i : 5'($urandom);
      end
      settle_check("rand");
      tick();
    end
    idle_inputs();
    // Let any clear started by the random phase finish
    for (int c = 0; c < NW + 2; c++) begin
      settle_check("drain");
      tick();
    end

    // Full clear: fill x1..x31, then clear with a write issued mid-clear
    for (int r = 1; r < NW; r++) begin
      we_a_i = 1'b1; waddr_a_i = 5'(r); wdata_a_i = 32'hA5000000 | DATA_WIDTH'(r);
      tick();
    end
    idle_inputs();
    read_all(5'd3);
    clr_req_i = 1'b1;
    settle_check("clr_start");
    tick();
    clr_req_i = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < NW + 4; c++) begin
      we_a_i = (c == 5); waddr_a_i = 5'd3; wdata_a_i = 32'h0ABC;
      for (int k = 0; k < NUM_RPORTS; k++) raddr_i[5*k +: 5] = 5'(c + k);
      settle_check("clearing");
      if (clr_busy_o) busy_cnt++;
      if (clr_done_o) done_cnt++;
      tick();
    end
    idle_inputs();
    chk("clr_busy_cycles", DATA_WIDTH'(busy_cnt), DATA_WIDTH'(NW - 1));
    chk("clr_done_pulses", DATA_WIDTH'(done_cnt), DATA_WIDTH'(1));
    for (int r = 0; r < NW; r += NUM_RPORTS) begin
      for (int k = 0; k < NUM_RPORTS; k++) raddr_i[5*k +: 5] = 5'(r + k);
      settle_check("after_clr");
    end
    read_all(5'd3);
    #1;
    chk("x3_dropped", rdata_o[DATA_WIDTH-1:0], '0);

    // Reset asserted in cycle 10 of a clear
    for (int r = 1; r < 6; r++) begin
      we_a_i = 1'b1; waddr_a_i = 5'(r); wdata_a_i = 32'h5A5A0000 | DATA_WIDTH'(r);
      tick();
    end
    idle_inputs();
    clr_req_i = 1'b1;
    tick();
    clr_req_i = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    read_all(5'd5);
    settle_check("pre_rst");
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    chk("mid_rst_busy", DATA_WIDTH'(clr_busy_o), '0);
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < NW + 4; c++) begin
      for (int k = 0; k < NUM_RPORTS; k++) raddr_i[5*k +: 5] = 5'(c + k);
      settle_check("post_rst");
      if (clr_done_o) done_cnt++;
      tick();
    end
    chk("no_done_after_rst", DATA_WIDTH'(done_cnt), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
